// File: rtl/csr_file_m_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zicsr_pkg / csr_file_m_if                                                |
// | Zicsr operand types and the execute-stage <-> CSR file bus.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package zicsr_pkg;
   typedef enum logic [1:0] {
      CSR_NONE = 2'd0,
      CSR_RW   = 2'd1,
      CSR_RS   = 2'd2,
      CSR_RC   = 2'd3
   } zicsr_csr_op_t;

   typedef struct packed {
      logic [29:0] base;
      logic [1:0]  mode;
   } zicsr_val_mtvec_t;
endpackage

interface csr_file_m_if #(
   parameter int XLEN = 32
);
   zicsr_pkg::zicsr_csr_op_t    i_op;
   logic                        i_we;
   logic [11:0]                 i_addr;
   logic [XLEN-1:0]             i_wdata;
   logic [XLEN-1:0]             i_pc;
   logic                        i_retire;
   logic                        i_trap_req;
   logic [XLEN-1:0]             i_trap_cause;
   logic [XLEN-1:0]             i_trap_tval;
   logic                        i_mret;
   logic                        i_irq_sw;
   logic                        i_irq_timer;
   logic                        i_irq_ext;
   logic [XLEN-1:0]             o_rdata;
   zicsr_pkg::zicsr_val_mtvec_t o_mtvec;
   logic [XLEN-1:0]             o_mepc;
   logic                        o_irq_req;
   logic [XLEN-1:0]             o_irq_cause;
   logic                        o_t_illegal_inst;

   modport master (
      output i_op, i_we, i_addr, i_wdata, i_pc, i_retire, i_trap_req, i_trap_cause,
             i_trap_tval, i_mret, i_irq_sw, i_irq_timer, i_irq_ext,
      input  o_rdata, o_mtvec, o_mepc, o_irq_req, o_irq_cause, o_t_illegal_inst
   );

   modport slave (
      input  i_op, i_we, i_addr, i_wdata, i_pc, i_retire, i_trap_req, i_trap_cause,
             i_trap_tval, i_mret, i_irq_sw, i_irq_timer, i_irq_ext,
      output o_rdata, o_mtvec, o_mepc, o_irq_req, o_irq_cause, o_t_illegal_inst
   );
endinterface
`default_nettype wire

// File: rtl/csr_file_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_file_m                                                               |
// | Machine-mode CSR file: trap stack, WARL masking, irq logic, counters.    |
// | COTM32_CSR_COUNTERS_EN enables mcycle(h)/minstret(h).                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csr_file_m #(
   parameter int              XLEN      = 32,
   parameter int              CNT_W     = 64,
   parameter logic [XLEN-1:0] HART_ID   = 32'd0,
   parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0000,
   parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100
) (
   input wire logic      i_clk,
   input wire logic      i_rst_n,
   csr_file_m_if.slave   bus
);
   localparam logic [11:0] c_addr_mstatus   = 12'h300;
   localparam logic [11:0] c_addr_misa      = 12'h301;
   localparam logic [11:0] c_addr_mie       = 12'h304;
   localparam logic [11:0] c_addr_mtvec     = 12'h305;
   localparam logic [11:0] c_addr_mscratch  = 12'h340;
   localparam logic [11:0] c_addr_mepc      = 12'h341;
   localparam logic [11:0] c_addr_mcause    = 12'h342;
   localparam logic [11:0] c_addr_mtval     = 12'h343;
   localparam logic [11:0] c_addr_mip       = 12'h344;
   localparam logic [11:0] c_addr_mcycle    = 12'hB00;
   localparam logic [11:0] c_addr_minstret  = 12'hB02;
   localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
   localparam logic [11:0] c_addr_minstreth = 12'hB82;
   localparam logic [11:0] c_addr_mhartid   = 12'hF14;
   localparam logic [XLEN-1:0] c_align_mask = ~(XLEN'(3));

   logic                        r_mstatus_mie;
   logic                        r_mstatus_mpie;
   logic [2:0]                  r_mie;        // {MEIE, MTIE, MSIE}
   logic [2:0]                  r_mip;        // {MEIP, MTIP, MSIP}
   zicsr_pkg::zicsr_val_mtvec_t r_mtvec;
   logic [XLEN-1:0]             r_mscratch;
   logic [XLEN-1:0]             r_mepc;
   logic [XLEN-1:0]             r_mcause;
   logic [XLEN-1:0]             r_mtval;

   logic [XLEN-1:0] w_mstatus, w_mie, w_mip, w_rdata, w_wval;
   logic            w_valid, w_active, w_illegal, w_csr_wr;
   logic [2:0]      w_pend;
   logic [63:0]     w_cyc64, w_ins64;

   assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
   assign w_mie     = {20'b0, r_mie[2], 3'b0, r_mie[1], 3'b0, r_mie[0], 3'b0};
   assign w_mip     = {20'b0, r_mip[2], 3'b0, r_mip[1], 3'b0, r_mip[0], 3'b0};

   always_comb begin
      w_valid = 1'b1;
      w_rdata = '0;
      case (bus.i_addr)
         c_addr_mstatus:   w_rdata = w_mstatus;
         c_addr_misa:      w_rdata = MISA_VAL;
         c_addr_mie:       w_rdata = w_mie;
         c_addr_mtvec:     w_rdata = r_mtvec;
         c_addr_mscratch:  w_rdata = r_mscratch;
         c_addr_mepc:      w_rdata = r_mepc;
         c_addr_mcause:    w_rdata = r_mcause;
         c_addr_mtval:     w_rdata = r_mtval;
         c_addr_mip:       w_rdata = w_mip;
         c_addr_mhartid:   w_rdata = HART_ID;
`ifdef COTM32_CSR_COUNTERS_EN
         c_addr_mcycle:    w_rdata = w_cyc64[31:0];
         c_addr_mcycleh:   w_rdata = w_cyc64[63:32];
         c_addr_minstret:  w_rdata = w_ins64[31:0];
         c_addr_minstreth: w_rdata = w_ins64[63:32];
`endif
         default:          w_valid = 1'b0;
      endcase
   end

   // Read-only space is addr[11:10]==2'b11; only a real write there is illegal.
   assign w_active  = (bus.i_op != zicsr_pkg::CSR_NONE);
   assign w_illegal = w_active & (~w_valid | ((bus.i_addr[11:10] == 2'b11) & bus.i_we));
   assign w_csr_wr  = w_active & bus.i_we & ~w_illegal & ~bus.i_trap_req & ~bus.i_mret;

   always_comb begin
      w_wval = w_rdata;
      case (bus.i_op)
         zicsr_pkg::CSR_RW: w_wval = bus.i_wdata;
         zicsr_pkg::CSR_RS: w_wval = w_rdata | bus.i_wdata;
         zicsr_pkg::CSR_RC: w_wval = w_rdata & ~bus.i_wdata;
         default:           w_wval = w_rdata;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mip          <= '0;
         r_mtvec        <= zicsr_pkg::zicsr_val_mtvec_t'(MTVEC_RST);
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
      end else begin
         r_mip <= {bus.i_irq_ext, bus.i_irq_timer, bus.i_irq_sw};
         if (bus.i_trap_req) begin
            r_mepc         <= bus.i_pc & c_align_mask;
            r_mcause       <= bus.i_trap_cause;
            r_mtval        <= bus.i_trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (bus.i_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else if (w_csr_wr) begin
            case (bus.i_addr)
               c_addr_mstatus: begin
                  r_mstatus_mie  <= w_wval[3];
                  r_mstatus_mpie <= w_wval[7];
               end
               c_addr_mie:      r_mie      <= {w_wval[11], w_wval[7], w_wval[3]};
               c_addr_mtvec: begin
                  // MODE 2/3 are reserved: keep the old mode, still take BASE.
                  r_mtvec.base <= w_wval[31:2];
                  if (w_wval[1:0] < 2'd2) r_mtvec.mode <= w_wval[1:0];
               end
               c_addr_mscratch: r_mscratch <= w_wval;
               c_addr_mepc:     r_mepc     <= w_wval & c_align_mask;
               c_addr_mcause:   r_mcause   <= w_wval;
               c_addr_mtval:    r_mtval    <= w_wval;
               default: ;
            endcase
         end
      end
   end

`ifdef COTM32_CSR_COUNTERS_EN
   logic [CNT_W-1:0] r_mcycle, r_minstret;
   logic [63:0]      w_cyc_inc, w_ins_step, w_cyc_nxt, w_ins_nxt;

   assign w_cyc64 = 64'(r_mcycle);
   assign w_ins64 = 64'(r_minstret);

   // A half-write replaces that half; the other half keeps counting without carry-in.
   always_comb begin
      w_cyc_inc  = 64'(r_mcycle + CNT_W'(1));
      w_ins_step = bus.i_retire ? 64'(r_minstret + CNT_W'(1)) : w_ins64;
      w_cyc_nxt  = w_cyc_inc;
      w_ins_nxt  = w_ins_step;
      if (w_csr_wr && bus.i_addr == c_addr_mcycle)     w_cyc_nxt = {w_cyc64[63:32], w_wval};
      if (w_csr_wr && bus.i_addr == c_addr_mcycleh)    w_cyc_nxt = {w_wval, w_cyc_inc[31:0]};
      if (w_csr_wr && bus.i_addr == c_addr_minstret)   w_ins_nxt = {w_ins64[63:32], w_wval};
      if (w_csr_wr && bus.i_addr == c_addr_minstreth)  w_ins_nxt = {w_wval, w_ins_step[31:0]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         r_mcycle   <= w_cyc_nxt[CNT_W-1:0];
         r_minstret <= w_ins_nxt[CNT_W-1:0];
      end
   end
`else
   localparam int c_unused_cnt_w = CNT_W;
   logic w_unused_retire;
   assign w_unused_retire = bus.i_retire;
   assign w_cyc64 = '0;
   assign w_ins64 = '0;
`endif

   assign w_pend = r_mip & r_mie;

   always_comb begin
      bus.o_irq_req   = r_mstatus_mie & (|w_pend);
      bus.o_irq_cause = '0;
      if (bus.o_irq_req) begin
         if (w_pend[2])      bus.o_irq_cause = {1'b1, 27'b0, 4'd11};
         else if (w_pend[0]) bus.o_irq_cause = {1'b1, 27'b0, 4'd3};
         else                bus.o_irq_cause = {1'b1, 27'b0, 4'd7};
      end
   end

   assign bus.o_rdata          = w_rdata;
   assign bus.o_t_illegal_inst = w_illegal;
   assign bus.o_mtvec          = r_mtvec;
   assign bus.o_mepc           = r_mepc;
endmodule
`default_nettype wire

// File: tb/tb_csr_file_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csr_file_m                                                            |
// | Directed vector table plus hand sequences for trap/irq/counter/reset.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_csr_file_m;
   localparam logic [31:0] c_hart  = 32'd5;
   localparam logic [31:0] c_mtvec = 32'h0000_1000;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   csr_file_m_if bus ();

   csr_file_m #(
      .XLEN      (32),
      .CNT_W     (64),
      .HART_ID   (c_hart),
      .MTVEC_RST (c_mtvec),
      .MISA_VAL  (32'h4000_0100)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      zicsr_pkg::zicsr_csr_op_t op;
      logic                     we;
      logic [11:0]              addr;
      logic [31:0]              wdata;
      logic                     chk_rd;
      logic [31:0]              rd;
      logic                     ill;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input zicsr_pkg::zicsr_csr_op_t op, input logic we, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic chk_rd, input logic [31:0] rd,
                      input logic ill);
      vec_t v;
      v.op = op; v.we = we; v.addr = addr; v.wdata = wdata;
      v.chk_rd = chk_rd; v.rd = rd; v.ill = ill;
      vecs.push_back(v);
   endtask

   task automatic drive(input zicsr_pkg::zicsr_csr_op_t op, input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata);
      bus.i_op = op; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
   endtask

   // One idle cycle reading addr, checked before the next rising edge.
   task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
      @(negedge clk);
      drive(zicsr_pkg::CSR_NONE, 1'b0, addr, 32'h0);
      #1 check(name, bus.o_rdata, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h000, 32'h0);
      bus.i_pc = '0; bus.i_retire = 1'b0; bus.i_trap_req = 1'b0;
      bus.i_trap_cause = '0; bus.i_trap_tval = '0; bus.i_mret = 1'b0;
      bus.i_irq_sw = 1'b0; bus.i_irq_timer = 1'b0; bus.i_irq_ext = 1'b0;

      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h300, 32'h0,          1'b1, 32'h0000_1800, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h305, 32'h8000_0003,  1'b1, c_mtvec,       1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h305, 32'h0,          1'b1, 32'h8000_0000, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h305, 32'h0000_2001,  1'b1, 32'h8000_0000, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h305, 32'h0000_3002,  1'b1, 32'h0000_2001, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h305, 32'h0,          1'b1, 32'h0000_3001, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'hF14, 32'h0000_0007,  1'b1, c_hart,        1'b1);
      add(zicsr_pkg::CSR_RS,   1'b0, 12'hF14, 32'h0,          1'b1, c_hart,        1'b0);
      add(zicsr_pkg::CSR_RS,   1'b1, 12'h7C0, 32'h0000_0001,  1'b0, 32'h0,         1'b1);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h7C0, 32'h0,          1'b0, 32'h0,         1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h300, 32'hFFFF_FFFF,  1'b1, 32'h0000_1800, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h300, 32'h0,          1'b1, 32'h0000_1888, 1'b0);
      add(zicsr_pkg::CSR_RC,   1'b1, 12'h300, 32'h0000_0008,  1'b1, 32'h0000_1888, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h300, 32'h0,          1'b1, 32'h0000_1880, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h304, 32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 1'b0);
      add(zicsr_pkg::CSR_RC,   1'b1, 12'h304, 32'h0000_0008,  1'b1, 32'h0000_0888, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h304, 32'h0,          1'b1, 32'h0000_0880, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h341, 32'h0000_0123,  1'b1, 32'h0000_0000, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h341, 32'h0,          1'b1, 32'h0000_0120, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h340, 32'hA5A5_5A5A,  1'b1, 32'h0000_0000, 1'b0);
      add(zicsr_pkg::CSR_RS,   1'b1, 12'h340, 32'h0000_000F,  1'b1, 32'hA5A5_5A5A, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h340, 32'h0,          1'b1, 32'hA5A5_5A5F, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h301, 32'h0000_0000,  1'b1, 32'h4000_0100, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h301, 32'h0,          1'b1, 32'h4000_0100, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h344, 32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h344, 32'h0,          1'b1, 32'h0000_0000, 1'b0);
      add(zicsr_pkg::CSR_RW,   1'b1, 12'h342, 32'h8000_0003,  1'b1, 32'h0000_0000, 1'b0);
      add(zicsr_pkg::CSR_NONE, 1'b0, 12'h342, 32'h0,          1'b1, 32'h8000_0003, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst o_mtvec", bus.o_mtvec, c_mtvec);
      check("rst o_mepc", bus.o_mepc, 32'h0);
      check("rst o_irq_req", {31'b0, bus.o_irq_req}, 32'h0);
      check("rst o_irq_cause", bus.o_irq_cause, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd("rst mstatus", 12'h300, 32'h0000_1800);
      rd("rst mtvec", 12'h305, c_mtvec);
      rd("rst mhartid", 12'hF14, c_hart);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         #1;
         if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), bus.o_rdata, vecs[i].rd);
         check($sformatf("vec%0d illegal", i), {31'b0, bus.o_t_illegal_inst}, {31'b0, vecs[i].ill});
      end
      @(negedge clk);
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h300, 32'h0);
      #1;
      check("o_mtvec", bus.o_mtvec, 32'h0000_3001);
      check("o_mepc", bus.o_mepc, 32'h0000_0120);

      // Interrupts: set MIE, raise timer+ext
      @(negedge clk);
      drive(zicsr_pkg::CSR_RS, 1'b1, 12'h300, 32'h0000_0008);
      bus.i_irq_timer = 1'b1; bus.i_irq_ext = 1'b1;
      #1 check("irq latency req", {31'b0, bus.o_irq_req}, 32'h0);
      @(negedge clk);
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h344, 32'h0);
      #1;
      check("irq ext req", {31'b0, bus.o_irq_req}, 32'h1);
      check("irq ext cause", bus.o_irq_cause, 32'h8000_000B);
      check("mip read", bus.o_rdata, 32'h0000_0880);
      @(negedge clk);
      bus.i_irq_ext = 1'b0;
      #1 check("irq ext hold", bus.o_irq_cause, 32'h8000_000B);
      @(negedge clk);
      #1 check("irq timer cause", bus.o_irq_cause, 32'h8000_0007);
      @(negedge clk);
      drive(zicsr_pkg::CSR_RS, 1'b1, 12'h304, 32'h0000_0008);
      bus.i_irq_sw = 1'b1;
      #1 check("irq sw masked", bus.o_irq_cause, 32'h8000_0007);
      @(negedge clk);
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h300, 32'h0);
      #1 check("irq sw cause", bus.o_irq_cause, 32'h8000_0003);
      @(negedge clk);
      bus.i_irq_sw = 1'b0; bus.i_irq_timer = 1'b0;
      #1 check("irq drop hold", {31'b0, bus.o_irq_req}, 32'h1);
      @(negedge clk);
      #1;
      check("irq idle req", {31'b0, bus.o_irq_req}, 32'h0);
      check("irq idle cause", bus.o_irq_cause, 32'h0);

      // Trap with a competing mscratch write that must be dropped
      @(negedge clk);
      drive(zicsr_pkg::CSR_RW, 1'b1, 12'h340, 32'h0);
      bus.i_trap_req = 1'b1; bus.i_pc = 32'h0000_0106;
      bus.i_trap_cause = 32'd2; bus.i_trap_tval = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.i_trap_req = 1'b0;
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h341, 32'h0);
      #1;
      check("trap mepc", bus.o_rdata, 32'h0000_0104);
      check("trap o_mepc", bus.o_mepc, 32'h0000_0104);
      rd("trap mcause", 12'h342, 32'd2);
      rd("trap mtval", 12'h343, 32'hDEAD_BEEF);
      rd("trap mstatus", 12'h300, 32'h0000_1880);
      rd("trap mscratch kept", 12'h340, 32'hA5A5_5A5F);
      @(negedge clk);
      drive(zicsr_pkg::CSR_RW, 1'b1, 12'h300, 32'h0);
      bus.i_mret = 1'b1;
      @(negedge clk);
      bus.i_mret = 1'b0;
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h300, 32'h0);
      #1 check("mret mstatus", bus.o_rdata, 32'h0000_1888);

`ifdef COTM32_CSR_COUNTERS_EN
      @(negedge clk);
      drive(zicsr_pkg::CSR_RW, 1'b1, 12'hB00, 32'hFFFF_FFFF);
      @(negedge clk);
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'hB00, 32'h0);
      #1 check("mcycle written", bus.o_rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      #1 check("mcycle wrap", bus.o_rdata, 32'h0);
      bus.i_addr = 12'hB80;
      #1 check("mcycleh carry", bus.o_rdata, 32'h1);
      @(negedge clk);
      drive(zicsr_pkg::CSR_RW, 1'b1, 12'hB02, 32'd5);
      bus.i_retire = 1'b1;
      @(negedge clk);
      bus.i_retire = 1'b0;
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'hB02, 32'h0);
      #1 check("minstret write wins", bus.o_rdata, 32'd5);
      @(negedge clk);
      bus.i_retire = 1'b1;
      #1 check("minstret pre-inc", bus.o_rdata, 32'd5);
      @(negedge clk);
      bus.i_retire = 1'b0;
      #1 check("minstret inc", bus.o_rdata, 32'd6);
      bus.i_addr = 12'hB82;
      #1 check("minstreth", bus.o_rdata, 32'd0);
`else
      @(negedge clk);
      drive(zicsr_pkg::CSR_RS, 1'b1, 12'hB00, 32'h1);
      #1 check("no-cnt mcycle ill", {31'b0, bus.o_t_illegal_inst}, 32'h1);
      drive(zicsr_pkg::CSR_RW, 1'b1, 12'hB82, 32'h1);
      #1 check("no-cnt minstreth ill", {31'b0, bus.o_t_illegal_inst}, 32'h1);
      drive(zicsr_pkg::CSR_RS, 1'b0, 12'hB80, 32'h0);
      #1 check("no-cnt mcycleh ill", {31'b0, bus.o_t_illegal_inst}, 32'h1);
`endif

      // Asynchronous reset in the middle of a pending mepc write
      @(negedge clk);
      drive(zicsr_pkg::CSR_RW, 1'b1, 12'h341, 32'h0000_0200);
      #2 rst_n = 1'b0;
      #1;
      check("async rst o_mepc", bus.o_mepc, 32'h0);
      check("async rst o_mtvec", bus.o_mtvec, c_mtvec);
      @(negedge clk);
      drive(zicsr_pkg::CSR_NONE, 1'b0, 12'h341, 32'h0);
      rst_n = 1'b1;
      #1 check("async rst mepc", bus.o_rdata, 32'h0);
      rd("async rst mstatus", 12'h300, 32'h0000_1800);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
